// File: rtl/uart_sched_pkg.sv
// Shared constants, FSM encoding and frame helpers for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int unsigned FRAME_LEN = 6;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned FIELD_W   = 7;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned SRC_W     = 2;
    localparam int unsigned NUM_SRC   = 4;

    localparam logic [BYTE_W-1:0] TAG_TIME  = 8'h01;
    localparam logic [BYTE_W-1:0] TAG_DATE  = 8'h02;
    localparam logic [BYTE_W-1:0] TAG_ALARM = 8'h03;
    localparam logic [BYTE_W-1:0] TAG_ACK   = 8'h04;

    localparam logic [SRC_W-1:0] SRC_ALARM = 2'd0;
    localparam logic [SRC_W-1:0] SRC_ACK   = 2'd1;
    localparam logic [SRC_W-1:0] SRC_TIME  = 2'd2;
    localparam logic [SRC_W-1:0] SRC_DATE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [BYTE_W-1:0]  tag;
        logic [FIELD_W-1:0] big;
        logic [FIELD_W-1:0] mid;
        logic [FIELD_W-1:0] less;
    } payload_t;

    // Byte at position idx of a frame: HEADER, TAG, B, M, L, CHK.
    function automatic logic [BYTE_W-1:0] frame_byte(
        input logic [IDX_W-1:0]  idx,
        input logic [BYTE_W-1:0] hdr,
        input payload_t          p
    );
        logic [BYTE_W-1:0] b;
        logic [BYTE_W-1:0] m;
        logic [BYTE_W-1:0] l;
        b = {1'b0, p.big};
        m = {1'b0, p.mid};
        l = {1'b0, p.less};
        case (idx)
            3'd0:    frame_byte = hdr;
            3'd1:    frame_byte = p.tag;
            3'd2:    frame_byte = b;
            3'd3:    frame_byte = m;
            3'd4:    frame_byte = l;
            default: frame_byte = p.tag ^ b ^ m ^ l;
        endcase
    endfunction

endpackage

// File: rtl/frame_serializer.sv
// Sends one 6-byte frame per start pulse over a valid/ready byte link, then idles for the gap.
module frame_serializer
    import uart_sched_pkg::*;
#(
    parameter int unsigned      GAP_CYCLES = 16,
    parameter logic [7:0]       HEADER     = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BYTE_W-1:0]  tag,
    input  logic [FIELD_W-1:0] big,
    input  logic [FIELD_W-1:0] mid,
    input  logic [FIELD_W-1:0] less,
    input  logic               tx_ready,
    output logic               tx_valid,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    sched_state_t       r_state;
    sched_state_t       w_state_nx;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nx;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   w_gap_nx;
    logic               r_tx_valid;
    logic               w_tx_valid_nx;
    logic [BYTE_W-1:0]  r_tx_data;
    logic [BYTE_W-1:0]  w_tx_data_nx;
    logic               w_accept;
    payload_t           w_payload;

    assign w_payload  = '{tag: tag, big: big, mid: mid, less: less};
    assign w_accept   = r_tx_valid & tx_ready;
    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign busy       = (r_state != ST_IDLE);

    // State, index, gap counter and registered byte outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_gap      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_idx      <= w_idx_nx;
            r_gap      <= w_gap_nx;
            r_tx_valid <= w_tx_valid_nx;
            r_tx_data  <= w_tx_data_nx;
        end
    end

    // Frame sequencing: next byte is loaded on acceptance of the current one.
    always_comb begin
        w_state_nx    = r_state;
        w_idx_nx      = r_idx;
        w_gap_nx      = r_gap;
        w_tx_valid_nx = r_tx_valid;
        w_tx_data_nx  = r_tx_data;
        frame_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx    = ST_SEND;
                    w_idx_nx      = '0;
                    w_tx_valid_nx = 1'b1;
                    w_tx_data_nx  = HEADER;
                end
            end
            ST_SEND: begin
                if (w_accept) begin
                    if (r_idx == IDX_LAST) begin
                        frame_done    = 1'b1;
                        w_tx_valid_nx = 1'b0;
                        w_tx_data_nx  = '0;
                        w_idx_nx      = '0;
                        if (GAP_CYCLES == 0) begin
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_state_nx = ST_GAP;
                            w_gap_nx   = GAP_INIT;
                        end
                    end else begin
                        w_idx_nx     = r_idx + 3'd1;
                        w_tx_data_nx = frame_byte(r_idx + 3'd1, HEADER, w_payload);
                    end
                end
            end
            ST_GAP: begin
                if (r_gap == '0) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_gap_nx = r_gap - GAP_W'(1);
                end
            end
            default: begin
                w_state_nx    = ST_IDLE;
                w_tx_valid_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates alarm, ack, time and date reports onto one UART byte transmitter.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned DATE_PERIOD = 10,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_enable,
    input  logic               sec_tick,
    input  logic               alarm_req,
    input  logic               ack_req,
    input  logic [FIELD_W-1:0] cur_hour,
    input  logic [FIELD_W-1:0] cur_min,
    input  logic [FIELD_W-1:0] cur_sec,
    input  logic [FIELD_W-1:0] cur_year,
    input  logic [FIELD_W-1:0] cur_day,
    input  logic [FIELD_W-1:0] cur_month,
    input  logic [FIELD_W-1:0] ack_big,
    input  logic [FIELD_W-1:0] ack_mid,
    input  logic [FIELD_W-1:0] ack_less,
    input  logic               tx_ready,
    output logic               tx_valid,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               busy,
    output logic               frame_done,
    output logic [SRC_W-1:0]   grant_id,
    output logic [7:0]         overrun_cnt
);

    localparam logic [7:0] DATE_LAST = 8'(DATE_PERIOD - 1);

    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_ovr;
    logic [7:0]         r_date_cnt;
    logic               w_date_hit;
    logic               w_grant;
    logic [SRC_W-1:0]   w_win;
    payload_t           w_payload;
    payload_t           r_snap;
    logic [SRC_W-1:0]   r_grant_id;
    logic [7:0]         r_overrun;
    logic [2:0]         w_ovr_n;
    logic [8:0]         w_ovr_sum;

    assign w_date_hit  = sec_tick && (r_date_cnt == DATE_LAST);
    assign w_req       = {w_date_hit, sec_tick, ack_req, alarm_req};
    assign w_grant     = !busy && tx_enable && (|r_pend);
    assign w_ovr       = w_req & r_pend & ~w_clr;
    assign w_ovr_n     = 3'(w_ovr[0]) + 3'(w_ovr[1]) + 3'(w_ovr[2]) + 3'(w_ovr[3]);
    assign w_ovr_sum   = {1'b0, r_overrun} + {6'd0, w_ovr_n};
    assign grant_id    = r_grant_id;
    assign overrun_cnt = r_overrun;

    // Fixed-priority winner, its payload and the flag it clears on grant.
    always_comb begin
        w_win     = SRC_ALARM;
        w_payload = '0;
        w_clr     = '0;
        if (r_pend[SRC_ALARM]) begin
            w_win     = SRC_ALARM;
            w_payload = {TAG_ALARM, cur_hour, cur_min, cur_sec};
        end else if (r_pend[SRC_ACK]) begin
            w_win     = SRC_ACK;
            w_payload = {TAG_ACK, ack_big, ack_mid, ack_less};
        end else if (r_pend[SRC_TIME]) begin
            w_win     = SRC_TIME;
            w_payload = {TAG_TIME, cur_hour, cur_min, cur_sec};
        end else if (r_pend[SRC_DATE]) begin
            w_win     = SRC_DATE;
            w_payload = {TAG_DATE, cur_year, cur_month, cur_day};
        end
        w_clr[w_win] = w_grant;
    end

    // Pending flags, date divider, payload snapshot and overrun counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend     <= '0;
            r_date_cnt <= '0;
            r_snap     <= '0;
            r_grant_id <= '0;
            r_overrun  <= '0;
        end else begin
            r_pend    <= (r_pend & ~w_clr) | w_req;
            r_overrun <= w_ovr_sum[8] ? 8'hFF : w_ovr_sum[7:0];
            if (sec_tick) begin
                r_date_cnt <= w_date_hit ? 8'd0 : r_date_cnt + 8'd1;
            end
            if (w_grant) begin
                r_snap     <= w_payload;
                r_grant_id <= w_win;
            end
        end
    end

    frame_serializer #(
        .GAP_CYCLES (GAP_CYCLES),
        .HEADER     (HEADER)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .start      (w_grant),
        .tag        (r_snap.tag),
        .big        (r_snap.big),
        .mid        (r_snap.mid),
        .less       (r_snap.less),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed scenario bench for uart_tx_scheduler (GAP_CYCLES=16, DATE_PERIOD=3).
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_enable;
    logic       sec_tick;
    logic       alarm_req;
    logic       ack_req;
    logic [6:0] cur_hour, cur_min, cur_sec;
    logic [6:0] cur_year, cur_day, cur_month;
    logic [6:0] ack_big, ack_mid, ack_less;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_done;
    logic [1:0] grant_id;
    logic [7:0] overrun_cnt;

    int checks = 0;
    int errors = 0;

    logic [47:0] fb_vec;
    logic        fb_ok;
    logic        fb_done_ok;
    logic [1:0]  fb_gid;
    int          fb_gap;
    int          idle_busy;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .GAP_CYCLES  (16),
        .DATE_PERIOD (3),
        .HEADER      (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_enable   (tx_enable),
        .sec_tick    (sec_tick),
        .alarm_req   (alarm_req),
        .ack_req     (ack_req),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .cur_sec     (cur_sec),
        .cur_year    (cur_year),
        .cur_day     (cur_day),
        .cur_month   (cur_month),
        .ack_big     (ack_big),
        .ack_mid     (ack_mid),
        .ack_less    (ack_less),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .grant_id    (grant_id),
        .overrun_cnt (overrun_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 7'(h);
        cur_min  = 7'(m);
        cur_sec  = 7'(s);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits for a frame and captures its six accepted bytes.
    task automatic get_frame(input int budget);
        int n;
        int w;
        fb_ok = 1'b0;
        fb_done_ok = 1'b1;
        fb_gap = 0;
        fb_vec = '0;
        fb_gid = 2'd0;
        n = 0;
        w = 0;
        while (!tx_valid && w < budget) begin
            if (busy) fb_gap++;
            tick();
            w++;
        end
        if (!tx_valid) return;
        fb_gid = grant_id;
        w = 0;
        while (n < 6 && w < budget) begin
            if (tx_valid && tx_ready) begin
                fb_vec = {fb_vec[39:0], tx_data};
                if ((n == 5) != frame_done) fb_done_ok = 1'b0;
                n++;
            end else if (frame_done) begin
                fb_done_ok = 1'b0;
            end
            tick();
            w++;
        end
        fb_ok = (n == 6);
    endtask

    // Counts busy cycles until the block returns to idle.
    task automatic wait_idle(input int budget);
        int w;
        idle_busy = 0;
        w = 0;
        while (busy && w < budget) begin
            idle_busy++;
            tick();
            w++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({tx_valid, tx_data, busy, frame_done, grant_id, overrun_cnt} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b data=%h busy=%b done=%b gid=%0d ovr=%0d required all 0",
                     tx_valid, tx_data, busy, frame_done, grant_id, overrun_cnt);
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got valid=%b busy=%b required 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_single_alarm();
        set_time(12, 34, 56);
        alarm_req = 1'b1;
        tick();
        alarm_req = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_latency_n1 got valid=%b required 0", tx_valid);
        end
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL t1_latency_n2 got valid=%b data=%h required 1 a5", tx_valid, tx_data);
        end
        get_frame(50);
        checks++;
        if (!fb_ok || fb_vec !== 48'hA5030C223815) begin
            errors++;
            $display("FAIL t1_frame got ok=%b %h required a5030c223815", fb_ok, fb_vec);
        end
        checks++;
        if (fb_done_ok !== 1'b1 || fb_gid !== 2'd0) begin
            errors++;
            $display("FAIL t1_done_gid got done_ok=%b gid=%0d required 1 0", fb_done_ok, fb_gid);
        end
        wait_idle(100);
        checks++;
        if (idle_busy != 16 || overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL t1_gap got busy_cycles=%0d ovr=%0d required 16 0", idle_busy, overrun_cnt);
        end
    endtask

    task automatic test_simultaneous();
        set_time(12, 34, 56);
        ack_big = 7'd5;
        ack_mid = 7'd6;
        ack_less = 7'd7;
        alarm_req = 1'b1;
        ack_req = 1'b1;
        sec_tick = 1'b1;
        tick();
        alarm_req = 1'b0;
        ack_req = 1'b0;
        sec_tick = 1'b0;
        get_frame(20);
        checks++;
        if (!fb_ok || fb_vec !== 48'hA5030C223815 || fb_gid !== 2'd0) begin
            errors++;
            $display("FAIL t2_alarm got ok=%b %h gid=%0d required a5030c223815 0", fb_ok, fb_vec, fb_gid);
        end
        get_frame(60);
        checks++;
        if (!fb_ok || fb_vec !== 48'hA50405060700 || fb_gid !== 2'd1 || fb_gap != 16) begin
            errors++;
            $display("FAIL t2_ack got ok=%b %h gid=%0d gap=%0d required a50405060700 1 16",
                     fb_ok, fb_vec, fb_gid, fb_gap);
        end
        get_frame(60);
        checks++;
        if (!fb_ok || fb_vec !== 48'hA5010C223817 || fb_gid !== 2'd2 || fb_gap != 16) begin
            errors++;
            $display("FAIL t2_time got ok=%b %h gid=%0d gap=%0d required a5010c223817 2 16",
                     fb_ok, fb_vec, fb_gid, fb_gap);
        end
        wait_idle(100);
        checks++;
        if (overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL t2_overrun got %0d required 0", overrun_cnt);
        end
    endtask

    task automatic test_date_period();
        int quiet_bad;
        apply_reset();
        set_time(1, 2, 3);
        cur_year = 7'd24;
        cur_month = 7'd5;
        cur_day = 7'd17;
        for (int t = 0; t < 3; t++) begin
            sec_tick = 1'b1;
            tick();
            sec_tick = 1'b0;
            get_frame(20);
            checks++;
            if (!fb_ok || fb_vec !== 48'hA50101020301 || fb_gid !== 2'd2) begin
                errors++;
                $display("FAIL t3_time_%0d got ok=%b %h gid=%0d required a50101020301 2", t, fb_ok, fb_vec, fb_gid);
            end
            if (t < 2) begin
                wait_idle(100);
                quiet_bad = 0;
                for (int i = 0; i < 5; i++) begin
                    if (tx_valid) quiet_bad++;
                    tick();
                end
                checks++;
                if (quiet_bad != 0) begin
                    errors++;
                    $display("FAIL t3_no_date_%0d got %0d valid cycles required 0", t, quiet_bad);
                end
            end
        end
        get_frame(60);
        checks++;
        if (!fb_ok || fb_vec !== 48'hA5021805110E || fb_gid !== 2'd3 || fb_gap != 16) begin
            errors++;
            $display("FAIL t3_date got ok=%b %h gid=%0d gap=%0d required a5021805110e 3 16",
                     fb_ok, fb_vec, fb_gid, fb_gap);
        end
        wait_idle(100);
    endtask

    task automatic test_stall();
        int w;
        int stall_bad;
        int quiet_bad;
        logic [31:0] rest;
        logic done_ok;
        set_time(12, 34, 56);
        alarm_req = 1'b1;
        tick();
        alarm_req = 1'b0;
        w = 0;
        while (!tx_valid && w < 20) begin
            tick();
            w++;
        end
        tick();
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h0C) begin
            errors++;
            $display("FAIL t4_byte2 got valid=%b data=%h required 1 0c", tx_valid, tx_data);
        end
        tx_ready = 1'b0;
        stall_bad = 0;
        for (int i = 0; i < 50; i++) begin
            alarm_req = (i == 10 || i == 25);
            tick();
            alarm_req = 1'b0;
            if (tx_valid !== 1'b1 || tx_data !== 8'h0C) stall_bad++;
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL t4_stall got %0d unstable cycles required 0", stall_bad);
        end
        tx_ready = 1'b1;
        rest = '0;
        done_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rest = {rest[23:0], tx_data};
            if ((k == 3) != frame_done) done_ok = 1'b0;
            tick();
        end
        checks++;
        if (rest !== 32'h0C223815 || done_ok !== 1'b1) begin
            errors++;
            $display("FAIL t4_rest got %h done_ok=%b required 0c223815 1", rest, done_ok);
        end
        checks++;
        if (overrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL t4_overrun got %0d required 1", overrun_cnt);
        end
        get_frame(60);
        checks++;
        if (!fb_ok || fb_vec !== 48'hA5030C223815 || fb_gid !== 2'd0) begin
            errors++;
            $display("FAIL t4_pending got ok=%b %h gid=%0d required a5030c223815 0", fb_ok, fb_vec, fb_gid);
        end
        wait_idle(100);
        quiet_bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx_valid) quiet_bad++;
            tick();
        end
        checks++;
        if (quiet_bad != 0) begin
            errors++;
            $display("FAIL t4_single_pending got %0d valid cycles required 0", quiet_bad);
        end
    endtask

    task automatic test_enable();
        int bad;
        tx_enable = 1'b0;
        set_time(1, 2, 3);
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) set_time(5, 6, 7);
            if (tx_valid || busy) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL t5_disabled got %0d active cycles required 0", bad);
        end
        tx_enable = 1'b1;
        set_time(8, 9, 10);
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL t5_start got valid=%b data=%h required 1 a5", tx_valid, tx_data);
        end
        set_time(11, 12, 13);
        get_frame(20);
        checks++;
        if (!fb_ok || fb_vec !== 48'hA50108090A0A || fb_gid !== 2'd2) begin
            errors++;
            $display("FAIL t5_snapshot got ok=%b %h gid=%0d required a50108090a0a 2", fb_ok, fb_vec, fb_gid);
        end
        wait_idle(100);
    endtask

    task automatic test_reset_mid();
        int w;
        int quiet_bad;
        set_time(12, 34, 56);
        alarm_req = 1'b1;
        tick();
        alarm_req = 1'b0;
        w = 0;
        while (!tx_valid && w < 20) begin
            tick();
            w++;
        end
        ack_req = 1'b1;
        tick();
        ack_req = 1'b0;
        tick();
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin
            errors++;
            $display("FAIL t6_byte3 got valid=%b data=%h required 1 22", tx_valid, tx_data);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({tx_valid, busy, frame_done, grant_id, overrun_cnt} !== 13'd0) begin
            errors++;
            $display("FAIL t6_after_reset got valid=%b busy=%b done=%b gid=%0d ovr=%0d required all 0",
                     tx_valid, busy, frame_done, grant_id, overrun_cnt);
        end
        quiet_bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx_valid || busy) quiet_bad++;
            tick();
        end
        checks++;
        if (quiet_bad != 0) begin
            errors++;
            $display("FAIL t6_flags_cleared got %0d active cycles required 0", quiet_bad);
        end
        alarm_req = 1'b1;
        tick();
        alarm_req = 1'b0;
        get_frame(20);
        checks++;
        if (!fb_ok || fb_vec !== 48'hA5030C223815 || fb_gid !== 2'd0 || !fb_done_ok) begin
            errors++;
            $display("FAIL t6_new_frame got ok=%b %h gid=%0d done_ok=%b required a5030c223815 0 1",
                     fb_ok, fb_vec, fb_gid, fb_done_ok);
        end
        wait_idle(100);
    endtask

    initial begin
        reset = 1'b1;
        tx_enable = 1'b1;
        sec_tick = 1'b0;
        alarm_req = 1'b0;
        ack_req = 1'b0;
        tx_ready = 1'b1;
        set_time(0, 0, 0);
        cur_year = '0;
        cur_day = '0;
        cur_month = '0;
        ack_big = '0;
        ack_mid = '0;
        ack_less = '0;
        #2;
        test_reset();
        test_single_alarm();
        test_simultaneous();
        test_date_period();
        test_stall();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
